// File: rtl/memory_ram_16bit_4bit_pkg.sv
// rtl/memory_ram_16bit_4bit_pkg.sv - default geometry for the 16x16 resettable scratch RAM
package memory_ram_16bit_4bit_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEFAULT_DEPTH = ram_depth(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/memory_ram_16bit_4bit.sv
// rtl/memory_ram_16bit_4bit.sv - single-port flop-based RAM, write-through, registered read data
module memory_ram_16bit_4bit
  import memory_ram_16bit_4bit_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  en,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;

  // Write-first: a write forwards din straight to the output register.
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = wen ? din : mem_q[address];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      if (en && wen) begin
        mem_q[address] <= din;
      end
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_memory_ram_16bit_4bit.sv
// tb/tb_memory_ram_16bit_4bit.sv - scoreboard bench for memory_ram_16bit_4bit
module tb_memory_ram_16bit_4bit;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        en;
  logic        wen;
  logic [3:0]  address;
  logic [15:0] out;

  memory_ram_16bit_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .en      (en),
    .wen     (wen),
    .address (address),
    .out     (out)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [16];
  logic [15:0] ref_out;
  int          pass_cnt;
  int          total_cnt;

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
    ref_out = 16'h0;
  endtask

  // One edge of stimulus; the reference model predicts out after that edge.
  task automatic op(input bit e, input bit w, input logic [3:0] a, input logic [15:0] d,
                    input string nm);
    @(negedge clk);
    en = e; wen = w; address = a; din = d;
    if (e) begin
      if (w) ref_mem[a] = d;
      ref_out = ref_mem[a];
    end
    exp_q.push_back('{nm, ref_out});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      exp_q.delete();
    end
    en = 1'b0;
    wen = 1'b0;
  endtask

  // Monitor: every active (non-reset) edge yields one output to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        check(e.name, out, e.exp);
      end
    end
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    model_clear();
    rst = 1'b1; en = 1'b1; wen = 1'b0; address = 4'd0; din = 16'h0;
    #5;
    check("reset_async", out, 16'h0);
    @(negedge clk);
    check("reset_held", out, 16'h0);
    rst = 1'b0;

    op(1, 0, 4'd0, 16'h0, "rd_after_reset_0");
    op(1, 0, 4'd5, 16'h0, "rd_after_reset_5");
    op(1, 0, 4'd10, 16'h0, "rd_after_reset_10");
    op(1, 0, 4'd15, 16'h0, "rd_after_reset_15");

    op(1, 1, 4'd10, 16'd25, "wr10_through");
    op(1, 0, 4'd5, 16'h0, "rd5_unwritten");
    op(1, 0, 4'd10, 16'h0, "rd10_back");

    op(1, 1, 4'd3, 16'hBEEF, "wr3_beef_through");
    op(1, 1, 4'd3, 16'h1234, "wr3_1234_through");
    op(1, 0, 4'd3, 16'h0, "rd3_overwritten");

    op(0, 1, 4'd7, 16'hFFFF, "idle_hold_1");
    op(0, 1, 4'd7, 16'hFFFF, "idle_hold_2");
    op(1, 0, 4'd7, 16'h0, "rd7_not_written");

    for (int i = 0; i < 16; i++) op(1, 1, 4'(i), 16'hA500 + 16'(i), "sweep_wr");
    for (int i = 0; i < 16; i++) op(1, 0, 4'(i), 16'h0, "sweep_rd");

    for (int i = 0; i < 200; i++) begin
      op(($urandom_range(0, 9) < 8), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
         16'($urandom), "random_op");
    end
    drain();

    #7;
    rst = 1'b1;
    #1;
    check("midrun_reset_out", out, 16'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) op(1, 0, 4'(i), 16'h0, "rd_after_midrun_reset");
    drain();

    // Write launched, then reset asserted before the edge that would commit it.
    @(negedge clk);
    en = 1'b1; wen = 1'b1; address = 4'd9; din = 16'hCAFE;
    #5;
    rst = 1'b1;
    #1;
    check("inflight_reset_out", out, 16'h0);
    en = 1'b0; wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    op(1, 0, 4'd9, 16'h0, "rd9_inflight_lost");
    op(1, 1, 4'd9, 16'h5A5A, "wr9_after_reset");
    op(1, 0, 4'd9, 16'h0, "rd9_back");
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
